// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM states
//   STALL_W     : width of the full-stall debug counter
//   onehot()    : index to one-hot vector, sized for the largest supported NUM_REQ
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int unsigned STALL_W  = 16;
    localparam int unsigned OH_W     = 8;
    localparam int unsigned OH_IDX_W = 3;

    // Callers truncate the result to their own requester count.
    function automatic logic [OH_W-1:0] onehot(input logic [OH_IDX_W-1:0] idx);
        onehot = OH_W'(1) << idx;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req  : per-requester request vector
//   last : index of the previous winner; search starts just above it and wraps
//   pick : index of the first requesting index after last (0 when none)
//   any  : at least one request is present
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   pick,
    output logic               any
);

    // Walk last+1 .. last+NUM_REQ (mod NUM_REQ); the first hit wins.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(last) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the ASYNC_FIFO write port among NUM_REQ producers.
//   wr_clk, rst            : FIFO write clock, synchronous active-high reset
//   req_valid/last/data    : per-requester word stream (data flattened, RAM_WIDTH each)
//   req_ready              : word accepted when req_valid[i] & req_ready[i]
//   grant                  : registered one-hot owner, zero when idle
//   write_en, write_data   : FIFO write strobe and data
//   fifo_full              : FIFO full flag (write domain)
//   stall_cnt              : saturating count of owner cycles blocked by fifo_full
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned RAM_WIDTH = 16,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                         wr_clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*RAM_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         write_en,
    output logic [RAM_WIDTH-1:0]         write_data,
    input  logic                         fifo_full,
    output logic [STALL_W-1:0]           stall_cnt
);

    localparam int unsigned OWN_W  = $clog2(NUM_REQ);
    localparam int unsigned BCNT_W = $clog2(MAX_BURST);

    arb_state_t         state, state_d;
    logic [OWN_W-1:0]   owner, owner_d;
    logic [OWN_W-1:0]   last_owner, last_owner_d;
    logic [BCNT_W-1:0]  burst_cnt, burst_cnt_d;
    logic [STALL_W-1:0] stall_cnt_d;
    logic [NUM_REQ-1:0] grant_d;

    logic [OWN_W-1:0]   pick;
    logic               any_req;
    logic               owner_valid;
    logic               owner_last;
    logic               in_burst;
    logic               xfer;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWN_W)
    ) u_picker (
        .req  (req_valid),
        .last (last_owner),
        .pick (pick),
        .any  (any_req)
    );

    // Data path: owner's word goes straight to the FIFO; reset blocks any write.
    always_comb begin
        owner_valid = req_valid[owner];
        owner_last  = req_last[owner];
        in_burst    = (state == ARB_BURST);
        xfer        = in_burst & owner_valid & ~fifo_full & ~rst;
        write_en    = xfer;
        req_ready   = '0;
        if (in_burst && !rst && !fifo_full) begin
            req_ready = NUM_REQ'(onehot(OH_IDX_W'(owner)));
        end
        write_data = '0;
        if (in_burst) begin
            write_data = req_data[owner*RAM_WIDTH +: RAM_WIDTH];
        end
    end

    // Next-state, ownership and counters.
    always_comb begin
        state_d      = state;
        owner_d      = owner;
        last_owner_d = last_owner;
        burst_cnt_d  = burst_cnt;
        stall_cnt_d  = stall_cnt;
        grant_d      = grant;
        unique case (state)
            ARB_IDLE: begin
                // Arbitration cycle: never moves data.
                if (any_req) begin
                    state_d      = ARB_BURST;
                    owner_d      = pick;
                    last_owner_d = pick;
                    burst_cnt_d  = '0;
                    grant_d      = NUM_REQ'(onehot(OH_IDX_W'(pick)));
                end
            end
            ARB_BURST: begin
                if (!owner_valid) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end else if (fifo_full) begin
                    if (stall_cnt != '1) begin
                        stall_cnt_d = stall_cnt + STALL_W'(1);
                    end
                end else begin
                    burst_cnt_d = burst_cnt + BCNT_W'(1);
                    if (owner_last || (burst_cnt == BCNT_W'(MAX_BURST - 1))) begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register; last_owner resets to the top index so requester 0 wins first.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= '0;
            last_owner <= OWN_W'(NUM_REQ - 1);
            burst_cnt  <= '0;
            stall_cnt  <= '0;
            grant      <= '0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            last_owner <= last_owner_d;
            burst_cnt  <= burst_cnt_d;
            stall_cnt  <= stall_cnt_d;
            grant      <= grant_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (NUM_REQ=4, RAM_WIDTH=16, MAX_BURST=16).
// Inputs change at the falling edge; outputs are checked 1 time unit later.
module tb_fifo_write_arbiter;

    logic        wr_clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        write_en;
    logic [15:0] write_data;
    logic        fifo_full;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    int req1_words;

    localparam logic [63:0] DATA_ALL = {16'hA003, 16'hA002, 16'hA001, 16'hA000};

    fifo_write_arbiter #(
        .NUM_REQ   (4),
        .RAM_WIDTH (16),
        .MAX_BURST (16)
    ) dut (
        .wr_clk     (wr_clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .grant      (grant),
        .write_en   (write_en),
        .write_data (write_data),
        .fifo_full  (fifo_full),
        .stall_cnt  (stall_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge wr_clk);
    endtask

    task automatic reset_cycle();
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;

        // Reset state; strobes forced low while rst is high even with a request.
        nxt();
        req_valid = 4'b0001;
        #1;
        chk("rst_we", 32'(write_en), 32'd0);
        chk("rst_rdy", 32'(req_ready), 32'd0);
        nxt();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        nxt();

        // Test 1: req0 three-word burst ending on req_last.
        req_valid = 4'b0001;
        req_data  = 64'h1;
        #1;
        chk("t1_bubble_we", 32'(write_en), 32'd0);
        chk("t1_bubble_rdy", 32'(req_ready), 32'd0);
        nxt();
        for (int w = 1; w <= 3; w++) begin
            req_data = 64'(w);
            req_last = (w == 3) ? 4'b0001 : 4'b0000;
            #1;
            chk("t1_grant", 32'(grant), 32'h1);
            chk("t1_we", 32'(write_en), 32'd1);
            chk("t1_wd", 32'(write_data), 32'(w));
            chk("t1_rdy", 32'(req_ready), 32'h1);
            nxt();
        end
        req_valid = '0;
        req_last  = '0;
        #1;
        chk("t1_idle_grant", 32'(grant), 32'd0);
        chk("t1_idle_we", 32'(write_en), 32'd0);
        nxt();

        // Test 2: all four requesters busy, bursts capped at 16, order 0,1,2,3,0.
        reset_cycle();
        req_valid = 4'b1111;
        req_data  = DATA_ALL;
        for (int b = 0; b < 5; b++) begin
            #1;
            chk("t2_bubble_grant", 32'(grant), 32'd0);
            chk("t2_bubble_we", 32'(write_en), 32'd0);
            nxt();
            for (int w = 0; w < 16; w++) begin
                #1;
                chk("t2_we", 32'(write_en), 32'd1);
                chk("t2_wd", 32'(write_data), 32'hA000 + 32'(b % 4));
                chk("t2_grant", 32'(grant), 32'd1 << (b % 4));
                nxt();
            end
        end
        req_valid = '0;
        nxt();

        // Test 3: req2 stalled five cycles by fifo_full, burst still 16 words total.
        reset_cycle();
        req_valid = 4'b0100;
        req_data  = DATA_ALL;
        #1;
        chk("t3_bubble_we", 32'(write_en), 32'd0);
        nxt();
        for (int w = 0; w < 4; w++) begin
            #1;
            chk("t3_pre_we", 32'(write_en), 32'd1);
            chk("t3_pre_wd", 32'(write_data), 32'hA002);
            nxt();
        end
        fifo_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("t3_stall_we", 32'(write_en), 32'd0);
            chk("t3_stall_rdy", 32'(req_ready), 32'd0);
            chk("t3_stall_grant", 32'(grant), 32'h4);
            nxt();
        end
        fifo_full = 1'b0;
        #1;
        chk("t3_stall_cnt", 32'(stall_cnt), 32'd5);
        for (int w = 0; w < 12; w++) begin
            #1;
            chk("t3_post_we", 32'(write_en), 32'd1);
            chk("t3_post_rdy", 32'(req_ready), 32'h4);
            nxt();
        end
        #1;
        chk("t3_release_grant", 32'(grant), 32'd0);
        chk("t3_release_we", 32'(write_en), 32'd0);
        req_valid = '0;
        nxt();

        // Test 4: req1 goes idle after 4 words while req3 waits.
        reset_cycle();
        req_valid  = 4'b1010;
        req_data   = DATA_ALL;
        req1_words = 0;
        #1;
        chk("t4_bubble_grant", 32'(grant), 32'd0);
        nxt();
        for (int w = 0; w < 4; w++) begin
            #1;
            chk("t4_grant1", 32'(grant), 32'h2);
            chk("t4_wd1", 32'(write_data), 32'hA001);
            if (write_en && req_ready[1]) req1_words++;
            nxt();
        end
        req_valid = 4'b1000;
        #1;
        chk("t4_drop_we", 32'(write_en), 32'd0);
        nxt();
        #1;
        chk("t4_bubble2_grant", 32'(grant), 32'd0);
        chk("t4_bubble2_we", 32'(write_en), 32'd0);
        nxt();
        #1;
        chk("t4_grant3", 32'(grant), 32'h8);
        chk("t4_we3", 32'(write_en), 32'd1);
        chk("t4_wd3", 32'(write_data), 32'hA003);
        chk("t4_req1_words", 32'(req1_words), 32'd4);
        nxt();

        // Test 5: reset pulse in the middle of req3's burst.
        rst = 1'b1;
        #1;
        chk("t5_rst_we", 32'(write_en), 32'd0);
        chk("t5_rst_rdy", 32'(req_ready), 32'd0);
        nxt();
        rst       = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("t5_after_grant", 32'(grant), 32'd0);
        chk("t5_after_we", 32'(write_en), 32'd0);
        nxt();
        #1;
        chk("t5_regrant", 32'(grant), 32'h1);
        chk("t5_wd", 32'(write_data), 32'hA000);
        nxt();

        // Test 6: long fifo_full hold saturates stall_cnt.
        req_valid = 4'b0001;
        fifo_full = 1'b1;
        for (int c = 0; c < 70000; c++) begin
            nxt();
        end
        #1;
        chk("t6_stall_sat", 32'(stall_cnt), 32'hFFFF);
        chk("t6_we", 32'(write_en), 32'd0);
        chk("t6_grant", 32'(grant), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
